clint: RTL

// - Core-local interruptor: bus responder behind the system bus's CLINT window (bus_clint_* port group).
// - Holds msip, 64-bit mtime and 64-bit mtimecmp; drives software/timer interrupt requests to the CSR/interrupt unit.
// - Addresses arrive already rebased to CLINT offset 0 (window size `CLINT_SIZE = 0x10000).

---
 rtl/clint.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clint.sv
// clint: core-local interruptor holding msip, mtime and mtimecmp behind a rebased bus window.
// Define CLINT_MTIME_WRITABLE_EN to let software write the two mtime halves.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`ADDR_WIDTH-1:0]     bus_clint_read_addr,
    input  logic [`ADDR_WIDTH-1:0]     bus_clint_write_addr,
    input  logic [`SIZE_WIDTH-1:0]     bus_clint_read_size,
    input  logic [`SIZE_WIDTH-1:0]     bus_clint_write_size,
    input  logic [`REG_DATA_WIDTH-1:0] bus_clint_data,
    input  logic                       bus_clint_rd,
    input  logic                       bus_clint_wr,
    output logic [`BUS_DATA_WIDTH-1:0] clint_bus_data,
    output logic                       clint_csr_msip,
    output logic                       clint_csr_mtip
);

    localparam logic [13:0] MSIP_WORD    = 14'h0000;
    localparam logic [13:0] CMP_LO_WORD  = 14'h1000;
    localparam logic [13:0] CMP_HI_WORD  = 14'h1001;
    localparam logic [13:0] TIME_LO_WORD = 14'h2FFE;
    localparam logic [13:0] TIME_HI_WORD = 14'h2FFF;
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] presc;
    logic        tick;
    logic [13:0] rd_word_addr;
    logic [13:0] wr_word_addr;
    logic [1:0]  rd_lane;
    logic [1:0]  wr_lane;
    logic [31:0] rd_word;
    logic [31:0] rd_mask;
    logic        msip_we;
    logic        cmp_lo_we;
    logic        cmp_hi_we;
    logic        time_lo_we;
    logic        time_hi_we;

    // Replace byte lanes lane..lane+size-1 of old_word; lanes past byte 3 are dropped.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0]             old_word,
        input logic [1:0]              lane,
        input logic [`SIZE_WIDTH-1:0]  size,
        input logic [31:0]             data
    );
        logic [3:0][7:0] res;
        logic [3:0][7:0] src;
        logic [2:0]      dst;
        res = old_word;
        src = data;
        for (int k = 0; k < 4; k++) begin
            dst = {1'b0, lane} + 3'(k);
            if ((`SIZE_WIDTH'(k) < size) && !dst[2])
                res[dst[1:0]] = src[2'(k)];
        end
        return res;
    endfunction

    assign rd_word_addr = bus_clint_read_addr[15:2];
    assign wr_word_addr = bus_clint_write_addr[15:2];
    assign rd_lane      = bus_clint_read_addr[1:0];
    assign wr_lane      = bus_clint_write_addr[1:0];

    assign msip_we   = bus_clint_wr && (wr_word_addr == MSIP_WORD);
    assign cmp_lo_we = bus_clint_wr && (wr_word_addr == CMP_LO_WORD);
    assign cmp_hi_we = bus_clint_wr && (wr_word_addr == CMP_HI_WORD);
`ifdef CLINT_MTIME_WRITABLE_EN
    assign time_lo_we = bus_clint_wr && (wr_word_addr == TIME_LO_WORD);
    assign time_hi_we = bus_clint_wr && (wr_word_addr == TIME_HI_WORD);
`else
    assign time_lo_we = 1'b0;
    assign time_hi_we = 1'b0;
`endif

    assign tick           = (presc == TICK_LAST);
    assign clint_csr_msip = msip;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = 32'h0;
        case (rd_word_addr)
            MSIP_WORD:    rd_word = {31'h0, msip};
            CMP_LO_WORD:  rd_word = mtimecmp[31:0];
            CMP_HI_WORD:  rd_word = mtimecmp[63:32];
            TIME_LO_WORD: rd_word = mtime[31:0];
            TIME_HI_WORD: rd_word = mtime[63:32];
            default:      rd_word = 32'h0;
        endcase
    end

    always_comb begin
        rd_mask = 32'hFFFF_FFFF;
        case (bus_clint_read_size)
            `SIZE_WIDTH'(0): rd_mask = 32'h0000_0000;
            `SIZE_WIDTH'(1): rd_mask = 32'h0000_00FF;
            `SIZE_WIDTH'(2): rd_mask = 32'h0000_FFFF;
            `SIZE_WIDTH'(3): rd_mask = 32'h00FF_FFFF;
            default:         rd_mask = 32'hFFFF_FFFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip           <= 1'b0;
            mtimecmp       <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc          <= 16'h0;
            clint_bus_data <= '0;
            clint_csr_mtip <= 1'b0;
        end else begin
            presc          <= tick ? 16'h0 : presc + 16'd1;
            clint_csr_mtip <= (mtime >= mtimecmp);
            if (bus_clint_rd)
                clint_bus_data <= (rd_word >> {rd_lane, 3'b000}) & rd_mask;
            if (msip_we && (wr_lane == 2'd0) && (bus_clint_write_size != '0))
                msip <= bus_clint_data[0];
            if (cmp_lo_we)
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], wr_lane, bus_clint_write_size, bus_clint_data);
            if (cmp_hi_we)
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wr_lane, bus_clint_write_size, bus_clint_data);
        end
    end

    // A software write to either half suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'h0;
        end else if (time_lo_we || time_hi_we) begin
            if (time_lo_we)
                mtime[31:0] <= merge_lanes(mtime[31:0], wr_lane, bus_clint_write_size, bus_clint_data);
            if (time_hi_we)
                mtime[63:32] <= merge_lanes(mtime[63:32], wr_lane, bus_clint_write_size, bus_clint_data);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule
